branch_resolve: RTL

Branch resolution unit for the five-stage MIPS pipeline. It carries each decode-stage branch prediction (`pred_takeD`, target, fall-through PC) down the D→E→M pipeline, latches the actual outcome from execute, and in memory stage compares the prediction with the outcome. It drives the predictor update (`branchM`, `actual_takeM`, `pcM`), a one-shot mispredict flush request with the corrected fetch PC, and optional accuracy counters.

---
 rtl/branch_resolve_if.sv | 38 +++
 rtl/branch_resolve.sv | 113 +++++++++++
 2 files changed

// File: rtl/branch_resolve_if.sv
// Branch-resolution bus: decode-stage prediction and pipeline control in, memory-stage
// predictor update, redirect and statistics out.
interface branch_resolve_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  // No valid/ready here: branchD qualifies pred_takeD/pcD/targetD/fallD in the cycle it is
  // high; branchM qualifies actual_takeM/pcM; mispredM qualifies redirect_pcM.
  logic              stallE;
  logic              stallM;
  logic              flushE;
  logic              flushM;
  logic              branchD;
  logic              pred_takeD;
  logic [ADDR_W-1:0] pcD;
  logic [ADDR_W-1:0] targetD;
  logic [ADDR_W-1:0] fallD;
  logic              actual_takeE;
  logic              branchM;
  logic              actual_takeM;
  logic [ADDR_W-1:0] pcM;
  logic              mispredM;
  logic [ADDR_W-1:0] redirect_pcM;
  logic [CNT_W-1:0]  branch_cnt;
  logic [CNT_W-1:0]  mispred_cnt;

  modport master (
    output stallE, stallM, flushE, flushM, branchD, pred_takeD, pcD, targetD, fallD,
           actual_takeE,
    input  branchM, actual_takeM, pcM, mispredM, redirect_pcM, branch_cnt, mispred_cnt
  );

  modport slave (
    input  stallE, stallM, flushE, flushM, branchD, pred_takeD, pcD, targetD, fallD,
           actual_takeE,
    output branchM, actual_takeM, pcM, mispredM, redirect_pcM, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve.sv
// Carries decode-stage branch predictions through E and M, compares against the resolved
// outcome in M, and raises a one-shot redirect. Define BRANCH_STATS_EN for retire counters.
module branch_resolve #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic            clk,
  input  logic            rst,
  branch_resolve_if.slave bus
);

  logic              r_validE;
  logic              r_predE;
  logic [ADDR_W-1:0] r_pcE;
  logic [ADDR_W-1:0] r_targetE;
  logic [ADDR_W-1:0] r_fallE;

  logic              r_validM;
  logic              r_predM;
  logic              r_takeM;
  logic              r_fired;
  logic [ADDR_W-1:0] r_pcM;
  logic [ADDR_W-1:0] r_targetM;
  logic [ADDR_W-1:0] r_fallM;

  logic w_wrong;
  logic w_mispred;
  logic w_retire;

  assign w_wrong   = r_predM ^ r_takeM;
  assign w_mispred = r_validM & w_wrong & ~r_fired;
  assign w_retire  = r_validM & ~bus.flushM & ~bus.stallM;

  // A mispredict in M means the E entry was fetched down the wrong path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validE  <= 1'b0;
      r_predE   <= 1'b0;
      r_pcE     <= '0;
      r_targetE <= '0;
      r_fallE   <= '0;
    end else if (bus.flushE || w_mispred) begin
      r_validE <= 1'b0;
    end else if (!bus.stallE) begin
      r_validE  <= bus.branchD;
      r_predE   <= bus.pred_takeD;
      r_pcE     <= bus.pcD;
      r_targetE <= bus.targetD;
      r_fallE   <= bus.fallD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_validM  <= 1'b0;
      r_predM   <= 1'b0;
      r_takeM   <= 1'b0;
      r_fired   <= 1'b0;
      r_pcM     <= '0;
      r_targetM <= '0;
      r_fallM   <= '0;
    end else if (bus.flushM) begin
      r_validM <= 1'b0;
      r_fired  <= 1'b0;
    end else if (bus.stallM) begin
      if (w_mispred) r_fired <= 1'b1;
    end else begin
      r_fired <= 1'b0;
      if (bus.stallE) begin
        r_validM <= 1'b0;
      end else begin
        // The entry leaving E on a mispredict edge is the one being killed.
        r_validM  <= r_validE & ~w_mispred;
        r_predM   <= r_predE;
        r_takeM   <= bus.actual_takeE;
        r_pcM     <= r_pcE;
        r_targetM <= r_targetE;
        r_fallM   <= r_fallE;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (w_retire) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_wrong && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;
`else
  logic w_unused_retire;
  assign w_unused_retire = w_retire;
  assign bus.branch_cnt  = {CNT_W{1'b0}};
  assign bus.mispred_cnt = {CNT_W{1'b0}};
`endif

  assign bus.branchM      = r_validM;
  assign bus.actual_takeM = r_takeM;
  assign bus.pcM          = r_pcM;
  assign bus.mispredM     = w_mispred;
  assign bus.redirect_pcM = r_takeM ? r_targetM : r_fallM;

endmodule
